// File: rtl/fir_sample_sequencer.sv
// Front-end sequencer for the 31-tap lowpass FIR: buffers sample strobes, paces
// fir_ready pulses, and captures fir_y after the compute window. FIR_ROUND_EN selects rounded/saturated out_y8.
module fir_sample_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 34
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic signed [7:0]  in_x,
  input  logic               clear,
  output logic               fir_ready,
  output logic signed [7:0]  fir_x,
  input  logic signed [17:0] fir_y,
  output logic               out_valid,
  output logic signed [17:0] out_y,
  output logic signed [7:0]  out_y8,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(SETTLE + 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST_WAIT = TW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

  state_t                   state_q, state_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [CW-1:0]            count_q, count_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic signed [7:0]        mem_q [FIFO_DEPTH];
  logic                     fir_ready_q, fir_ready_d;
  logic signed [7:0]        fir_x_q, fir_x_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [17:0]       out_y_q, out_y_d;
  logic signed [7:0]        out_y8_q, out_y8_d;
  logic                     busy_q, busy_d;
  logic                     overflow_q, overflow_d;
  logic [7:0]               drop_count_q, drop_count_d;
  logic                     full, push, pop, drop;

  function automatic logic signed [7:0] narrow_y(input logic signed [17:0] y);
`ifdef FIR_ROUND_EN
    logic signed [18:0] biased;
    logic signed [8:0]  q;
    biased = {y[17], y} + 19'sd512;
    q = 9'(biased >>> 10);
    if (q > 9'sd127)       narrow_y = 8'sd127;
    else if (q < -9'sd128) narrow_y = 8'sh80;
    else                   narrow_y = q[7:0];
`else
    narrow_y = 8'(y >>> 10);
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    fir_ready_d = 1'b0;
    fir_x_d     = fir_x_q;
    out_valid_d = 1'b0;
    out_y_d     = out_y_q;
    out_y8_d    = out_y8_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          fir_ready_d = 1'b1;
          fir_x_d     = mem_q[rd_ptr_q];
          timer_d     = TW'(1);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // timer is 1 in the fir_ready cycle, so it reads SETTLE one cycle before capture
        timer_d = timer_q + TW'(1);
        if (timer_q == LAST_WAIT) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_y_d     = fir_y;
        out_y8_d    = narrow_y(fir_y);
        out_valid_d = 1'b1;
        timer_d     = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    full     = (count_q == FULL_CNT);
    push     = in_valid && (!full || pop);
    drop     = in_valid && full && !pop;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    // clear takes effect before a same-cycle drop is counted
    overflow_d   = clear ? 1'b0 : overflow_q;
    drop_count_d = clear ? 8'd0 : drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      drop_count_d = (drop_count_d == 8'hFF) ? 8'hFF : drop_count_d + 8'd1;
    end

    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_x;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fir_ready_q  <= 1'b0;
      fir_x_q      <= '0;
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      out_y8_q     <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fir_ready_q  <= fir_ready_d;
      fir_x_q      <= fir_x_d;
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      out_y8_q     <= out_y8_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign fir_ready  = fir_ready_q;
  assign fir_x      = fir_x_q;
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_y8     = out_y8_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: the bench stands in for the FIR (drives fir_y) and
// predicts issue/capture timing, FIFO drops and out_y8 from a queue-based model.
module tb_fir_sample_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int SETTLE     = 34;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  in_x = '0;
  logic               clear = 1'b0;
  logic               fir_ready;
  logic signed [7:0]  fir_x;
  logic signed [17:0] fir_y = '0;
  logic               out_valid;
  logic signed [17:0] out_y;
  logic signed [7:0]  out_y8;
  logic               busy;
  logic               overflow;
  logic [7:0]         drop_count;

  fir_sample_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .SETTLE(SETTLE)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_x(in_x), .clear(clear),
    .fir_ready(fir_ready), .fir_x(fir_x), .fir_y(fir_y), .out_valid(out_valid),
    .out_y(out_y), .out_y8(out_y8), .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {int off; bit vld; logic signed [7:0] x; bit clr;} stim_t;
  typedef struct {int cyc; logic signed [7:0] x;} rdy_t;
  typedef struct {int cyc; logic signed [17:0] y; logic signed [7:0] y8; logic signed [7:0] fx;} ov_t;

  stim_t              stim[$];
  rdy_t               rdy_log[$];
  ov_t                ov_log[$];
  int                 cyc = 0;
  int                 n_chk = 0;
  int                 n_fail = 0;
  bit                 fy_mode = 1'b0;
  logic signed [17:0] fy_const = '0;
  int                 exp_dc = 0;
  bit                 exp_ov = 1'b0;
  int                 run_base = 0;

  function automatic logic signed [17:0] fy_hash(input int c);
    logic [31:0] h;
    h = 32'(c) * 32'h9E3779B1;
    return h[31:14];
  endfunction

  function automatic int exp_y8(input int y);
    int v;
`ifdef FIR_ROUND_EN
    v = (y + 512) >>> 10;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`else
    v = y >>> 10;
`endif
    return v;
  endfunction

  initial forever #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
    #1;
    fir_y = fy_mode ? fy_hash(cyc) : fy_const;
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      if (fir_ready) rdy_log.push_back('{cyc, fir_x});
      if (out_valid) ov_log.push_back('{cyc, out_y, out_y8, fir_x});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic run_stim(input string tag);
    int A[$];
    int R[$];
    logic signed [7:0] X[$];
    int idx, last, waited, a, r, prev_r, cnt, dc;
    bit pop, ov;
    logic signed [17:0] ey;
    rdy_log.delete();
    ov_log.delete();
    run_base = cyc;
    last = stim[stim.size()-1].off;
    idx = 0;
    for (int t = 0; t <= last; t++) begin
      in_valid = 1'b0;
      clear    = 1'b0;
      if (idx < stim.size() && stim[idx].off == t) begin
        in_valid = stim[idx].vld;
        in_x     = stim[idx].x;
        clear    = stim[idx].clr;
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    waited = 0;
    while (busy && waited < 4000) begin
      step();
      waited++;
    end
    n_chk++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s drain: busy=%0d after %0d cycles, required 0", tag, busy, waited);
    end
    repeat (3) step();

    prev_r = -100000;
    dc = exp_dc;
    ov = exp_ov;
    foreach (stim[i]) begin
      a = run_base + stim[i].off;
      if (stim[i].clr) begin
        dc = 0;
        ov = 1'b0;
      end
      if (stim[i].vld) begin
        cnt = 0;
        pop = 1'b0;
        foreach (A[j]) begin
          if (A[j] + 1 <= a && R[j] - 1 >= a) cnt++;
          if (R[j] - 1 == a) pop = 1'b1;
        end
        if (cnt >= FIFO_DEPTH && !pop) begin
          dc = (dc < 255) ? dc + 1 : 255;
          ov = 1'b1;
        end else begin
          r = a + 2;
          if (prev_r + SETTLE + 2 > r) r = prev_r + SETTLE + 2;
          A.push_back(a);
          R.push_back(r);
          X.push_back(stim[i].x);
          prev_r = r;
        end
      end
    end

    n_chk++;
    if (rdy_log.size() != R.size()) begin
      n_fail++;
      $display("FAIL %s ready_count: got %0d required %0d", tag, rdy_log.size(), R.size());
    end
    for (int j = 0; j < R.size() && j < rdy_log.size(); j++) begin
      n_chk++;
      if (rdy_log[j].cyc != R[j] || rdy_log[j].x !== X[j]) begin
        n_fail++;
        $display("FAIL %s ready[%0d]: got cycle %0d x %0d required cycle %0d x %0d",
                 tag, j, rdy_log[j].cyc, rdy_log[j].x, R[j], X[j]);
      end
    end
    n_chk++;
    if (ov_log.size() != R.size()) begin
      n_fail++;
      $display("FAIL %s valid_count: got %0d required %0d", tag, ov_log.size(), R.size());
    end
    for (int j = 0; j < R.size() && j < ov_log.size(); j++) begin
      ey = fy_mode ? fy_hash(R[j] + SETTLE) : fy_const;
      n_chk++;
      if (ov_log[j].cyc != R[j] + SETTLE + 1 || ov_log[j].y !== ey ||
          int'(ov_log[j].y8) != exp_y8(int'(ey)) || ov_log[j].fx !== X[j]) begin
        n_fail++;
        $display("FAIL %s valid[%0d]: got cycle %0d y %0d y8 %0d fir_x %0d required cycle %0d y %0d y8 %0d fir_x %0d",
                 tag, j, ov_log[j].cyc, ov_log[j].y, ov_log[j].y8, ov_log[j].fx,
                 R[j] + SETTLE + 1, ey, exp_y8(int'(ey)), X[j]);
      end
    end
    n_chk++;
    if (int'(drop_count) != dc || overflow !== ov) begin
      n_fail++;
      $display("FAIL %s drops: got drop_count %0d overflow %0d required %0d %0d",
               tag, drop_count, overflow, dc, ov);
    end
    exp_dc = dc;
    exp_ov = ov;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    n_chk++;
    if (fir_ready !== 1'b0 || fir_x !== 8'sd0 || out_valid !== 1'b0 || out_y !== 18'sd0) begin
      n_fail++;
      $display("FAIL reset_data: got ready %0d x %0d valid %0d y %0d required all 0",
               fir_ready, fir_x, out_valid, out_y);
    end
    n_chk++;
    if (out_y8 !== 8'sd0 || busy !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status: got y8 %0d busy %0d ovf %0d drops %0d required all 0",
               out_y8, busy, overflow, drop_count);
    end
    reset_n = 1'b1;
    step();
    exp_dc = 0;
    exp_ov = 1'b0;
  endtask

  task automatic test_prime();
    fy_mode = 1'b1;
    stim.delete();
    for (int k = 0; k < 32; k++) stim.push_back('{k * 37, 1'b1, 8'sd0, 1'b0});
    run_stim("prime");
  endtask

  task automatic test_impulse();
    int lit;
`ifdef FIR_ROUND_EN
    lit = 0;
`else
    lit = -1;
`endif
    fy_mode  = 1'b0;
    fy_const = -18'sd100;
    stim.delete();
    stim.push_back('{0, 1'b1, 8'sd100, 1'b0});
    run_stim("impulse");
    n_chk++;
    if (rdy_log.size() < 1 || rdy_log[0].cyc != run_base + 2 || rdy_log[0].x !== 8'sd100) begin
      n_fail++;
      $display("FAIL impulse_ready: got %0d pulses, first at offset %0d, required offset 2 x 100",
               rdy_log.size(), rdy_log.size() > 0 ? rdy_log[0].cyc - run_base : -1);
    end
    n_chk++;
    if (ov_log.size() < 1 || ov_log[0].cyc != run_base + 37 || ov_log[0].y !== -18'sd100 ||
        int'(ov_log[0].y8) != lit) begin
      n_fail++;
      $display("FAIL impulse_out: got %0d pulses, first offset %0d y %0d y8 %0d, required offset 37 y -100 y8 %0d",
               ov_log.size(), ov_log.size() > 0 ? ov_log[0].cyc - run_base : -1,
               ov_log.size() > 0 ? ov_log[0].y : 18'sd0, ov_log.size() > 0 ? ov_log[0].y8 : 8'sd0, lit);
    end
  endtask

  task automatic test_back_to_back();
    fy_mode = 1'b1;
    stim.delete();
    for (int k = 0; k < 6; k++) stim.push_back('{k, 1'b1, 8'($urandom), k == 0});
    run_stim("burst");
    n_chk++;
    if (overflow !== 1'b1 || drop_count !== 8'd1 || rdy_log.size() != 5) begin
      n_fail++;
      $display("FAIL burst_accept: got ovf %0d drops %0d issued %0d required 1 1 5",
               overflow, drop_count, rdy_log.size());
    end
    for (int j = 1; j < rdy_log.size(); j++) begin
      n_chk++;
      if (rdy_log[j].cyc - rdy_log[j-1].cyc != 36) begin
        n_fail++;
        $display("FAIL burst_spacing[%0d]: got %0d required 36", j, rdy_log[j].cyc - rdy_log[j-1].cyc);
      end
    end
  endtask

  task automatic test_random();
    int off;
    fy_mode = 1'b1;
    for (int round = 0; round < 4; round++) begin
      stim.delete();
      off = 0;
      for (int k = 0; k < 14; k++) begin
        stim.push_back('{off, 1'b1, 8'($urandom), $urandom_range(0, 7) == 0});
        off += ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 80);
      end
      run_stim("random");
    end
  endtask

  task automatic test_clear_drop();
    int waited;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_x = 8'(k + 1);
      step();
    end
    in_valid = 1'b0;
    n_chk++;
    if (overflow !== 1'b1 || drop_count !== 8'd3) begin
      n_fail++;
      $display("FAIL drop_setup: got ovf %0d drops %0d required 1 3", overflow, drop_count);
    end
    step();
    in_valid = 1'b1;
    clear = 1'b1;
    step();
    in_valid = 1'b0;
    clear = 1'b0;
    n_chk++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL clear_with_drop: got ovf %0d drops %0d required 1 1", overflow, drop_count);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_chk++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL lone_clear: got ovf %0d drops %0d required 0 0", overflow, drop_count);
    end
    waited = 0;
    while (busy && waited < 400) begin
      step();
      waited++;
    end
    n_chk++;
    if (busy) begin
      n_fail++;
      $display("FAIL clear_drain: busy=%0d required 0", busy);
    end
    repeat (3) step();
    exp_dc = 0;
    exp_ov = 1'b0;
  endtask

  task automatic test_saturate();
    fy_mode = 1'b1;
    stim.delete();
    for (int k = 0; k < 330; k++) stim.push_back('{k, 1'b1, 8'($urandom), k == 0});
    run_stim("saturate");
    n_chk++;
    if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got drops %0d ovf %0d required 255 1", drop_count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int w, r;
    rdy_log.delete();
    ov_log.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_x = 8'sh5A;
      step();
    end
    in_valid = 1'b0;
    w = 0;
    while (rdy_log.size() == 0 && w < 20) begin
      step();
      w++;
    end
    n_chk++;
    if (rdy_log.size() == 0) begin
      n_fail++;
      $display("FAIL midreset_issue: got 0 ready pulses required 1");
    end else begin
      r = rdy_log[0].cyc;
      while (cyc < r + 10) step();
      reset_n = 1'b0;
      #1;
      n_chk++;
      if (fir_ready !== 1'b0 || fir_x !== 8'sd0 || out_valid !== 1'b0 || out_y !== 18'sd0 ||
          out_y8 !== 8'sd0 || busy !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
        n_fail++;
        $display("FAIL midreset_outputs: got x %0d y %0d y8 %0d busy %0d ovf %0d drops %0d required all 0",
                 fir_x, out_y, out_y8, busy, overflow, drop_count);
      end
      step();
      reset_n = 1'b1;
      exp_dc = 0;
      exp_ov = 1'b0;
      rdy_log.delete();
      ov_log.delete();
      repeat (80) step();
      n_chk++;
      if (rdy_log.size() != 0 || ov_log.size() != 0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_abandon: got %0d ready %0d valid busy %0d required 0 0 0",
                 rdy_log.size(), ov_log.size(), busy);
      end
    end
    fy_mode = 1'b1;
    stim.delete();
    stim.push_back('{0, 1'b1, 8'sd77, 1'b0});
    run_stim("after_reset");
  endtask

  task automatic test_round();
    int vals[3];
    int lits[3];
    vals = '{1536, 131071, -131072};
`ifdef FIR_ROUND_EN
    lits = '{2, 127, -128};
`else
    lits = '{1, 127, -128};
`endif
    fy_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fy_const = 18'(vals[i]);
      stim.delete();
      stim.push_back('{0, 1'b1, 8'($urandom), 1'b0});
      run_stim("round");
      n_chk++;
      if (ov_log.size() < 1 || int'(ov_log[0].y8) != lits[i]) begin
        n_fail++;
        $display("FAIL round_%0d: got %0d pulses y8 %0d required y8 %0d",
                 vals[i], ov_log.size(), ov_log.size() > 0 ? ov_log[0].y8 : 8'sd0, lits[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_impulse();
    test_back_to_back();
    test_random();
    test_clear_drop();
    test_saturate();
    test_reset_mid();
    test_round();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
